// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and helpers for load_store_unit.
//   - size encodings SZ_BYTE / SZ_HALF / SZ_WORD (SZ_ILL is the reserved code)
//   - FSM state type lsu_state_t and debug struct lsu_dbg_t
//   - lane_extract: pick a byte/half lane from a word and sign/zero extend it
//   - lane_merge:   replace a byte/half lane of a word with new store data
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_STORE     = 3'd2,
        ST_RMW_READ  = 3'd3,
        ST_RMW_WRITE = 3'd4,
        ST_RESP      = 3'd5
    } lsu_state_t;

    typedef struct packed {
        lsu_state_t state;
        logic       write;   // latched direction of the request in flight
    } lsu_dbg_t;

    function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                                 input logic [1:0]  size,
                                                 input logic [1:0]  off,
                                                 input logic        sgn);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (off)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = off[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_BYTE: r = {{24{sgn & b[7]}}, b};
            SZ_HALF: r = {{16{sgn & h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] lane_merge(input logic [31:0] word,
                                               input logic [15:0] wdata,
                                               input logic [1:0]  size,
                                               input logic [1:0]  off);
        logic [31:0] r;
        r = word;
        if (size == SZ_BYTE) begin
            case (off)
                2'd0:    r[7:0]   = wdata[7:0];
                2'd1:    r[15:8]  = wdata[7:0];
                2'd2:    r[23:16] = wdata[7:0];
                default: r[31:24] = wdata[7:0];
            endcase
        end else if (size == SZ_HALF) begin
            if (off[1]) r[31:16] = wdata;
            else        r[15:0]  = wdata;
        end
        return r;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// load_store_unit_if: pipeline-side request/response channel of the LSU.
//   Handshake: a transfer happens on a posedge where valid & ready are both 1;
//   valid never waits on ready, and the payload is only meaningful while valid=1.
//   master: the pipeline (drives req_*, resp_ready)
//   slave:  the load_store_unit (drives req_ready, resp_*)
interface load_store_unit_if #(parameter int ADDR_W = 32);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [31:0]       resp_rdata;
    logic              resp_error;

    modport master (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_error
    );

    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_error
    );
endinterface

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: combinational lane logic shared by the load and RMW paths.
//   rdata      in  word read from memory
//   size/off   in  latched access size and byte offset
//   sgn        in  sign-extend loads when 1
//   wdata      in  low 16 bits of the latched store data
//   load_data  out extracted and extended load result
//   merge_data out rdata with the addressed lane replaced by wdata
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  size,
    input  logic [1:0]  off,
    input  logic        sgn,
    input  logic [15:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);
    assign load_data  = lane_extract(rdata, size, off, sgn);
    assign merge_data = lane_merge(rdata, wdata, size, off);
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: initiator front end for a word-organised data memory.
//   clock, reset_n   single clock, synchronous active-low reset
//   bus              load_store_unit_if.slave request/response channel
//   mem_*            word address, write data, write/read strobes, read data
//   dbg              FSM state and latched direction
// Optional (macro LSU_PERF_COUNT_EN): perf_loads/perf_stores/perf_errors,
//   counting completed responses, updated when RESP hands back to IDLE.
// Sub-word stores take a read-modify-write pass; memory strobes are decoded
// from state only, so a reset always suppresses any pending write.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int DEPTH  = 128,
    parameter int ADDR_W = 32
)(
    input  logic               clock,
    input  logic               reset_n,
    load_store_unit_if.slave   bus,
    output logic [31:0]        mem_address,
    output logic [31:0]        mem_write_data,
    output logic               mem_write_enable,
    output logic               mem_read_enable,
    input  logic [31:0]        mem_read_data,
`ifdef LSU_PERF_COUNT_EN
    output logic [31:0]        perf_loads,
    output logic [31:0]        perf_stores,
    output logic [31:0]        perf_errors,
`endif
    output lsu_dbg_t           dbg
);
    localparam logic [ADDR_W-3:0] DEPTH_IDX = (ADDR_W-2)'(DEPTH);

    lsu_state_t        state;
    logic [ADDR_W-3:0] a_word;
    logic [1:0]        a_off;
    logic [1:0]        a_size;
    logic              a_signed;
    logic              a_write;
    logic [31:0]       a_wdata;
    logic [31:0]       merge_q;
    logic [31:0]       load_data;
    logic [31:0]       merge_data;
    logic              acc_err;

    // Error decode on the live request, used only at the acceptance edge.
    always_comb begin
        acc_err = 1'b0;
        case (bus.req_size)
            SZ_HALF: acc_err = bus.req_addr[0];
            SZ_WORD: acc_err = |bus.req_addr[1:0];
            SZ_ILL:  acc_err = 1'b1;
            default: acc_err = 1'b0;
        endcase
        if (bus.req_addr[ADDR_W-1:2] >= DEPTH_IDX) acc_err = 1'b1;
    end

    lsu_lane_align u_align (
        .rdata      (mem_read_data),
        .size       (a_size),
        .off        (a_off),
        .sgn        (a_signed),
        .wdata      (a_wdata[15:0]),
        .load_data  (load_data),
        .merge_data (merge_data)
    );

    assign bus.req_ready    = (state == ST_IDLE);
    assign mem_address      = 32'(a_word);
    assign mem_read_enable  = (state == ST_LOAD)  || (state == ST_RMW_READ);
    assign mem_write_enable = (state == ST_STORE) || (state == ST_RMW_WRITE);
    assign mem_write_data   = (state == ST_STORE) ? a_wdata : merge_q;
    assign dbg              = '{state: state, write: a_write};

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state          <= ST_IDLE;
            a_word         <= '0;
            a_off          <= '0;
            a_size         <= '0;
            a_signed       <= 1'b0;
            a_write        <= 1'b0;
            a_wdata        <= '0;
            merge_q        <= '0;
            bus.resp_valid <= 1'b0;
            bus.resp_rdata <= '0;
            bus.resp_error <= 1'b0;
`ifdef LSU_PERF_COUNT_EN
            perf_loads     <= '0;
            perf_stores    <= '0;
            perf_errors    <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        a_word   <= bus.req_addr[ADDR_W-1:2];
                        a_off    <= bus.req_addr[1:0];
                        a_size   <= bus.req_size;
                        a_signed <= bus.req_signed;
                        a_write  <= bus.req_write;
                        a_wdata  <= bus.req_wdata;
                        if (acc_err) begin
                            bus.resp_valid <= 1'b1;
                            bus.resp_rdata <= '0;
                            bus.resp_error <= 1'b1;
                            state          <= ST_RESP;
                        end else if (!bus.req_write) begin
                            state <= ST_LOAD;
                        end else if (bus.req_size == SZ_WORD) begin
                            state <= ST_STORE;
                        end else begin
                            state <= ST_RMW_READ;
                        end
                    end
                end
                ST_LOAD: begin
                    bus.resp_valid <= 1'b1;
                    bus.resp_rdata <= load_data;
                    bus.resp_error <= 1'b0;
                    state          <= ST_RESP;
                end
                ST_STORE, ST_RMW_WRITE: begin
                    bus.resp_valid <= 1'b1;
                    bus.resp_rdata <= '0;
                    bus.resp_error <= 1'b0;
                    state          <= ST_RESP;
                end
                ST_RMW_READ: begin
                    merge_q <= merge_data;
                    state   <= ST_RMW_WRITE;
                end
                ST_RESP: begin
                    if (bus.resp_ready) begin
                        bus.resp_valid <= 1'b0;
                        state          <= ST_IDLE;
`ifdef LSU_PERF_COUNT_EN
                        if (bus.resp_error) perf_errors <= perf_errors + 32'd1;
                        else if (a_write)   perf_stores <= perf_stores + 32'd1;
                        else                perf_loads  <= perf_loads + 32'd1;
`endif
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: table of directed requests plus hand-written
// sequences for response back-pressure and reset during a read-modify-write.
module tb_load_store_unit;
    import lsu_pkg::*;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset_n;
    always #5 clock = ~clock;

    load_store_unit_if #(.ADDR_W(32)) bus ();

    logic [31:0] mem_address, mem_write_data, mem_read_data;
    logic        mem_write_enable, mem_read_enable;
    lsu_dbg_t    dbg;
`ifdef LSU_PERF_COUNT_EN
    logic [31:0] perf_loads, perf_stores, perf_errors;
`endif

    load_store_unit #(.DEPTH(128), .ADDR_W(32)) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .bus              (bus.slave),
        .mem_address      (mem_address),
        .mem_write_data   (mem_write_data),
        .mem_write_enable (mem_write_enable),
        .mem_read_enable  (mem_read_enable),
        .mem_read_data    (mem_read_data),
`ifdef LSU_PERF_COUNT_EN
        .perf_loads       (perf_loads),
        .perf_stores      (perf_stores),
        .perf_errors      (perf_errors),
`endif
        .dbg              (dbg)
    );

    // ---------------- memory model and strobe monitor ----------------
    logic [31:0] mem [0:127];
    assign mem_read_data = mem[mem_address[6:0]];
    always @(posedge clock) if (mem_write_enable) mem[mem_address[6:0]] <= mem_write_data;

    int          rd_cnt = 0, wr_cnt = 0, both_cnt = 0;
    logic [31:0] last_wdata = '0;
    always @(negedge clock) begin
        if (mem_read_enable) rd_cnt++;
        if (mem_write_enable) begin
            wr_cnt++;
            last_wdata = mem_write_data;
        end
        if (mem_read_enable && mem_write_enable) both_cnt++;
    end

    // ---------------- scoreboard ----------------
    int errors = 0, checks = 0;
    logic [31:0] exp_q[$];
    int exp_loads = 0, exp_stores = 0, exp_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_req(input logic wr, input logic [1:0] sz, input logic sg,
                             input logic [31:0] addr, input logic [31:0] wdata);
        bus.req_write  = wr;
        bus.req_size   = sz;
        bus.req_signed = sg;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        bus.req_valid  = 1'b1;
    endtask

    // Waits at negedges for resp_valid; lat counts negedges seen after the
    // current point (1 = first negedge). lat=0 on timeout.
    task automatic wait_resp(output int lat);
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clock);
            if (bus.resp_valid) begin
                lat = k;
                break;
            end
        end
        if (lat == 0) begin
            errors++;
            checks++;
            $display("FAIL resp_timeout: got no resp_valid expected resp_valid within 10 cycles");
        end
    endtask

    // Issues one request with resp_ready high; returns response and strobe counts.
    task automatic do_req(input logic wr, input logic [1:0] sz, input logic sg,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err, output int lat,
                          output int nrd, output int nwr);
        int rd0, wr0, n;
        @(negedge clock);
        drive_req(wr, sz, sg, addr, wdata);
        n = 0;
        while (!bus.req_ready && n < 20) begin
            @(negedge clock);
            n++;
        end
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        @(posedge clock);
        #1 bus.req_valid = 1'b0;
        wait_resp(lat);
        rdata = bus.resp_rdata;
        err   = bus.resp_error;
        @(posedge clock);
        #1;
        nrd = rd_cnt - rd0;
        nwr = wr_cnt - wr0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        wr;
        logic [1:0]  sz;
        logic        sg;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        int          exp_rd;
        int          exp_wr;
        logic [31:0] exp_wdata;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs [NV];

    initial begin
        logic [31:0] rdata;
        logic        err;
        int          lat, nrd, nwr, n;

        // wr sz sg addr wdata | rdata err lat rd wr wdata
        vecs[0]  = '{0, SZ_BYTE, 1, 32'h10,  32'h0,        32'hFFFFFFBB, 0, 2, 1, 0, 32'h0};
        vecs[1]  = '{0, SZ_HALF, 0, 32'h12,  32'h0,        32'h00008899, 0, 2, 1, 0, 32'h0};
        vecs[2]  = '{0, SZ_WORD, 0, 32'h10,  32'h0,        32'h8899AABB, 0, 2, 1, 0, 32'h0};
        vecs[3]  = '{0, SZ_BYTE, 0, 32'h13,  32'h0,        32'h00000088, 0, 2, 1, 0, 32'h0};
        vecs[4]  = '{0, SZ_HALF, 1, 32'h10,  32'h0,        32'hFFFFAABB, 0, 2, 1, 0, 32'h0};
        vecs[5]  = '{1, SZ_BYTE, 0, 32'h11,  32'h1234565A, 32'h0,        0, 3, 1, 1, 32'h88995ABB};
        vecs[6]  = '{0, SZ_WORD, 0, 32'h10,  32'h0,        32'h88995ABB, 0, 2, 1, 0, 32'h0};
        vecs[7]  = '{1, SZ_WORD, 0, 32'h14,  32'hDEADBEEF, 32'h0,        0, 2, 0, 1, 32'hDEADBEEF};
        vecs[8]  = '{1, SZ_HALF, 0, 32'h16,  32'hFFFF1234, 32'h0,        0, 3, 1, 1, 32'h1234BEEF};
        vecs[9]  = '{0, SZ_WORD, 0, 32'h14,  32'h0,        32'h1234BEEF, 0, 2, 1, 0, 32'h0};
        vecs[10] = '{1, SZ_WORD, 0, 32'h06,  32'h11111111, 32'h0,        1, 1, 0, 0, 32'h0};
        vecs[11] = '{0, SZ_ILL,  0, 32'h10,  32'h0,        32'h0,        1, 1, 0, 0, 32'h0};
        vecs[12] = '{0, SZ_WORD, 0, 32'h200, 32'h0,        32'h0,        1, 1, 0, 0, 32'h0};
        vecs[13] = '{0, SZ_HALF, 0, 32'h11,  32'h0,        32'h0,        1, 1, 0, 0, 32'h0};
        vecs[14] = '{0, SZ_BYTE, 1, 32'h1FF, 32'h0,        32'h0000007F, 0, 2, 1, 0, 32'h0};

        for (int i = 0; i < 128; i++) mem[i] = 32'h0;
        mem[4]   = 32'h8899AABB;
        mem[5]   = 32'h00000000;
        mem[127] = 32'h7F123456;

        // ---------------- reset ----------------
        reset_n        = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_size   = SZ_WORD;
        bus.req_signed = 1'b0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.resp_ready = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        chk("reset req_ready",  32'(bus.req_ready),  32'd1);
        chk("reset resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("reset resp_rdata", bus.resp_rdata,      32'd0);
        chk("reset resp_error", 32'(bus.resp_error), 32'd0);

        // ---------------- table ----------------
        for (int i = 0; i < NV; i++) begin
            do_req(vecs[i].wr, vecs[i].sz, vecs[i].sg, vecs[i].addr, vecs[i].wdata,
                   rdata, err, lat, nrd, nwr);
            exp_q.push_back(vecs[i].exp_rdata);
            chk($sformatf("v%0d rdata", i), rdata, exp_q.pop_front());
            chk($sformatf("v%0d error", i), 32'(err), 32'(vecs[i].exp_err));
            chk($sformatf("v%0d latency", i), lat, vecs[i].exp_lat);
            chk($sformatf("v%0d read_strobes", i), nrd, vecs[i].exp_rd);
            chk($sformatf("v%0d write_strobes", i), nwr, vecs[i].exp_wr);
            if (vecs[i].exp_wr != 0)
                chk($sformatf("v%0d write_data", i), last_wdata, vecs[i].exp_wdata);
            if (vecs[i].exp_err)  exp_errors++;
            else if (vecs[i].wr)  exp_stores++;
            else                  exp_loads++;
        end
        chk("mem word4 after byte store", mem[4], 32'h88995ABB);
        chk("mem word5 after half store", mem[5], 32'h1234BEEF);

        // ---------------- back-pressure on the response ----------------
        bus.resp_ready = 1'b0;
        @(negedge clock);
        drive_req(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0);
        @(posedge clock);
        #1 drive_req(1'b0, SZ_WORD, 1'b0, 32'h14, 32'h0);   // queued, must wait
        wait_resp(lat);
        for (int h = 0; h < 5; h++) begin
            chk($sformatf("hold%0d resp_valid", h), 32'(bus.resp_valid), 32'd1);
            chk($sformatf("hold%0d resp_rdata", h), bus.resp_rdata, 32'h88995ABB);
            chk($sformatf("hold%0d req_ready", h),  32'(bus.req_ready),  32'd0);
            if (h < 4) @(negedge clock);
        end
        bus.resp_ready = 1'b1;
        @(negedge clock);
        chk("release req_ready",  32'(bus.req_ready),  32'd1);
        chk("release resp_valid", 32'(bus.resp_valid), 32'd0);
        @(posedge clock);
        #1 bus.req_valid = 1'b0;
        @(negedge clock);
        chk("queued accepted req_ready", 32'(bus.req_ready), 32'd0);
        wait_resp(lat);
        chk("queued latency", lat, 1);
        chk("queued rdata", bus.resp_rdata, 32'h1234BEEF);
        @(posedge clock);
        #1;
        exp_loads += 2;

`ifdef LSU_PERF_COUNT_EN
        chk("perf_loads",  perf_loads,  exp_loads);
        chk("perf_stores", perf_stores, exp_stores);
        chk("perf_errors", perf_errors, exp_errors);
`endif

        // ---------------- reset during RMW_READ of a half store ----------------
        @(negedge clock);
        drive_req(1'b1, SZ_HALF, 1'b0, 32'h10, 32'h0000CAFE);
        n = wr_cnt;
        @(posedge clock);
        #1;
        reset_n       = 1'b0;
        bus.req_valid = 1'b0;
        @(negedge clock);
        chk("rmw_read dbg_state", 32'(dbg.state), 32'(ST_RMW_READ));
        @(posedge clock);
        @(negedge clock);
        chk("rst_mid req_ready",  32'(bus.req_ready),  32'd1);
        chk("rst_mid resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_mid resp_rdata", bus.resp_rdata,      32'd0);
        chk("rst_mid resp_error", 32'(bus.resp_error), 32'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);
        chk("rst_mid write_strobes", wr_cnt - n, 0);
        chk("rst_mid mem word4", mem[4], 32'h88995ABB);
`ifdef LSU_PERF_COUNT_EN
        chk("perf_loads cleared",  perf_loads,  32'd0);
        chk("perf_stores cleared", perf_stores, 32'd0);
        chk("perf_errors cleared", perf_errors, 32'd0);
`endif

        do_req(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, rdata, err, lat, nrd, nwr);
        chk("post_reset load rdata", rdata, 32'h88995ABB);
        chk("post_reset load error", 32'(err), 32'd0);

        chk("read and write strobes together", both_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator-side front end for the word-organised data memory. It accepts byte, halfword and word load/store requests from the pipeline over a valid/ready handshake.
- It drives the memory's word address, write data, write enable and read enable.
- Sub-word stores are performed as read-modify-write. Sub-word loads are extracted and sign- or zero-extended.
- It sits between the MEM pipeline stage and data_memory, and returns one response per request.

Parameters:
- DEPTH, 128, number of 32-bit words in the attached memory; word index must be < DEPTH.
- ADDR_W, 32, width of the pipeline byte address.

Ports:
- clock  in  1  single clock; all state updates on posedge clock.
- reset_n  in  1  synchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request.
- req_write  in  1  1=store, 0=load.
- req_size  in  2  00=byte, 01=half, 10=word, 11=illegal.
- req_signed  in  1  loads only: 1=sign-extend, 0=zero-extend.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data; only the low bits are used for byte/half.
- resp_valid  out  1  response present.
- resp_ready  in  1  pipeline accepts the response.
- resp_rdata  out  32  load result; 0 for stores and errors.
- resp_error  out  1  misaligned, illegal size, or out-of-range access.
- mem_address  out  32  word index, equal to req_addr >> 2.
- mem_write_data  out  32  word to write.
- mem_write_enable  out  1  write strobe; the memory writes on posedge clock.
- mem_read_enable  out  1  read strobe; mem_read_data is combinational.
- mem_read_data  in  32  memory read data.

Behaviour:
- FSM states: IDLE, LOAD, STORE, RMW_READ, RMW_WRITE, RESP.
- Reset (reset_n=0 at posedge) forces:
  - state=IDLE;
  - resp_valid=0, resp_rdata=0, resp_error=0;
  - latched request registers cleared.
- Memory strobes are decoded from state and are 0 in IDLE/RESP. Therefore no write occurs in the cycle after a reset, including a reset taken mid-RMW.
- IDLE:
  - req_ready=1. A handshake (req_valid & req_ready) latches addr, size, signed, write and wdata.
  - Error check at acceptance:
    - size=11;
    - half with addr[0]≠0;
    - word with addr[1:0]≠0;
    - (addr>>2) ≥ DEPTH.
  - On error: go to RESP with resp_error=1 and resp_rdata=0. No memory strobe is ever asserted.
  - Otherwise: load → LOAD; word store → STORE; byte/half store → RMW_READ.
- req_ready=0 in every state except IDLE. There is no request overlap and at most one request is outstanding.
- LOAD (1 cycle):
  - mem_read_enable=1, mem_address=latched word index.
  - At the posedge, extract the lane (byte lane = addr[1:0], half lane = addr[1]), extend per signed, and register into resp_rdata. Go to RESP.
- STORE (1 cycle): mem_write_enable=1, mem_write_data=wdata. Go to RESP.
- RMW_READ (1 cycle): mem_read_enable=1. The merge register captures mem_read_data with the addressed lane replaced by wdata[7:0] or wdata[15:0]. Go to RMW_WRITE.
- RMW_WRITE (1 cycle): mem_write_enable=1, mem_write_data=merge register. Go to RESP.
- RESP:
  - resp_valid=1, with resp_rdata and resp_error held stable until resp_ready=1.
  - At the posedge with resp_ready=1: clear resp_valid and go to IDLE. The next request is accepted one cycle later (no IDLE bypass).
- Latency, counted from the acceptance edge to the first cycle with resp_valid=1 (resp_ready tied high):
  - load: 2 cycles;
  - word store: 2 cycles;
  - sub-word store: 3 cycles;
  - error: 1 cycle.
- Throughput with resp_ready tied high: one load or word store per 3 cycles.
- A request held with req_valid=1 while req_ready=0 is not consumed. req_* may change freely after acceptance without effect.
- mem_read_enable and mem_write_enable are never asserted in the same cycle.

Optional Feature:
- Macro: LSU_PERF_COUNT_EN.
- Defined:
  - Adds outputs perf_loads[31:0], perf_stores[31:0] and perf_errors[31:0].
  - Each counts completed responses of its kind, incremented at the RESP→IDLE edge.
  - Counters wrap at 2^32 and clear on reset.
- Undefined: the counter ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package lsu_pkg holds:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD;
  - the FSM state typedef/localparams;
  - the lane-extract and lane-merge functions.
- Sub-module lsu_lane_align (combinational) does extract/extend for loads and merge for stores. It is shared by the LOAD and RMW_READ paths.

Test Plan:
- Preload word 4=0x8899AABB. Load byte signed at addr 0x10 → resp_rdata=0xFFFFFFBB. Load half unsigned at 0x12 → 0x00008899. Load word at 0x10 → 0x8899AABB, 2 cycles after acceptance, error=0.
- Store byte 0x5A at 0x11 over word 4=0x8899AABB → read strobe then write strobe on consecutive cycles, mem_write_data=0x88995ABB, response after 3 cycles. A following word load of 0x10 returns 0x88995ABB.
- Misaligned word store at 0x06 and size=11 → resp_error=1, resp_rdata=0, no mem strobe asserted. Out-of-range load at addr 0x200 (word 128, DEPTH=128) → resp_error=1.
- Hold resp_ready=0 for 5 cycles after a load → resp_valid and resp_rdata stable and req_ready=0 throughout. Raise resp_ready → IDLE next cycle, and a queued req_valid is accepted then.
- Drop reset_n during RMW_READ of a half store → no mem_write_enable pulse; memory word unchanged; next cycle req_ready=1 and all resp_* outputs are 0.
- With LSU_PERF_COUNT_EN: 3 loads, 2 stores and 1 error → perf_loads=3, perf_stores=2, perf_errors=1. Reset → all three counters 0.
